// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the single-bus CPU datapath.
//   - word width and word type
//   - ALU opcode encodings (carried on the MUL port of cpu_project)
//   - slot indices into the datapath register file array
package cpu_pkg;

   localparam int unsigned WORD_W = 32;
   typedef logic [WORD_W-1:0] word_t;

   localparam logic [4:0] ALU_ADD  = 5'b00011;
   localparam logic [4:0] ALU_SUB  = 5'b00100;
   localparam logic [4:0] ALU_AND  = 5'b00101;
   localparam logic [4:0] ALU_OR   = 5'b00110;
   localparam logic [4:0] ALU_SHR  = 5'b00111;
   localparam logic [4:0] ALU_SHRA = 5'b01000;
   localparam logic [4:0] ALU_SHL  = 5'b01001;
   localparam logic [4:0] ALU_ROR  = 5'b01010;
   localparam logic [4:0] ALU_ROL  = 5'b01011;
   localparam logic [4:0] ALU_MUL  = 5'b01110;
   localparam logic [4:0] ALU_DIV  = 5'b01111;
   localparam logic [4:0] ALU_NEG  = 5'b10000;
   localparam logic [4:0] ALU_NOT  = 5'b10001;

   // R1..R15 occupy slots 0..14; special registers follow.
   localparam int unsigned NUM_GPR  = 15;
   localparam int unsigned IDX_PC   = 15;
   localparam int unsigned IDX_IR   = 16;
   localparam int unsigned IDX_MAR  = 17;
   localparam int unsigned IDX_MDR  = 18;
   localparam int unsigned IDX_Y    = 19;
   localparam int unsigned IDX_ZHI  = 20;
   localparam int unsigned IDX_ZLO  = 21;
   localparam int unsigned IDX_HI   = 22;
   localparam int unsigned IDX_LO   = 23;
   localparam int unsigned NUM_REGS = 24;

   // Slot index of general-purpose register Rn (n = 1..15).
   function automatic int unsigned gpr_idx(input int unsigned n);
      return n - 1;
   endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: purely combinational ALU, 64-bit result.
//   op_i  : 5-bit opcode (ALU_* in cpu_pkg); unknown opcodes give 0
//   a_i   : operand A (Y register)
//   b_i   : operand B (bus)
//   cin_i : carry-in for ADD/SUB
//   res_o : {high, low}; single-word operations leave the high half 0
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [4:0]  op_i,
   input  word_t       a_i,
   input  word_t       b_i,
   input  logic        cin_i,
   output logic [63:0] res_o
);

   logic signed [63:0] prod;
   logic               div_zero;
   logic               div_ovf;
   word_t              quo;
   word_t              rem;
   logic [4:0]         sh;
   logic [63:0]        rot;

   assign prod = $signed({{WORD_W{a_i[WORD_W-1]}}, a_i}) *
                 $signed({{WORD_W{b_i[WORD_W-1]}}, b_i});

   // Division by zero and MIN/-1 are resolved explicitly so the divider
   // never sees an operand pair without a defined result.
   assign div_zero = (b_i == '0);
   assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == '1);

   always_comb begin
      quo = '1;
      rem = a_i;
      if (div_ovf) begin
         quo = 32'h8000_0000;
         rem = '0;
      end else if (!div_zero) begin
         quo = word_t'($signed(a_i) / $signed(b_i));
         rem = word_t'($signed(a_i) % $signed(b_i));
      end
   end

   always_comb begin
      res_o = '0;
      sh    = b_i[4:0];
      rot   = '0;
      case (op_i)
         ALU_ADD:  res_o[31:0] = a_i + b_i + {31'b0, cin_i};
         ALU_SUB:  res_o[31:0] = a_i - b_i - {31'b0, cin_i};
         ALU_AND:  res_o[31:0] = a_i & b_i;
         ALU_OR:   res_o[31:0] = a_i | b_i;
         ALU_SHR:  res_o[31:0] = a_i >> sh;
         ALU_SHRA: res_o[31:0] = word_t'($signed(a_i) >>> sh);
         ALU_SHL:  res_o[31:0] = a_i << sh;
         // Rotates shift a doubled copy so the wrapped bits fall into place.
         ALU_ROR: begin
            rot         = {a_i, a_i} >> sh;
            res_o[31:0] = rot[31:0];
         end
         ALU_ROL: begin
            rot         = {a_i, a_i} << sh;
            res_o[31:0] = rot[63:32];
         end
         ALU_MUL:  res_o = prod;
         ALU_DIV:  res_o = {rem, quo};
         ALU_NEG:  res_o[31:0] = '0 - b_i;
         ALU_NOT:  res_o[31:0] = ~b_i;
         default:  res_o = '0;
      endcase
   end

endmodule

// File: rtl/cpu_reg32.sv
// cpu_reg32: generic 32-bit register, load enable, async active-low clear.
//   clk_i   : rising-edge clock
//   rst_n_i : asynchronous clear, active low
//   en_i    : load d_i on the clock edge; otherwise hold
//   d_i/q_o : data in / registered data out
module cpu_reg32
   import cpu_pkg::*;
(
   input  logic  clk_i,
   input  logic  rst_n_i,
   input  logic  en_i,
   input  word_t d_i,
   output word_t q_o
);

   word_t q_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         q_q <= '0;
      end else if (en_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/cpu_project.sv
// cpu_project: 32-bit single-bus CPU datapath, sequenced externally.
//   Clock                   : rising-edge clock for every register
//   Clear                   : asynchronous clear, active low
//   PCout..R4out            : bus-drive selects (MDR > PC > ZLow > ZHigh > R2 > R4)
//   MARin,PCin,MDRin,IRin,
//   Yin,HIin,LOin,R1in..R15in : register load enables (load from the bus)
//   ZHighIn/ZLowIn          : load Z halves from the ALU result
//   IncPC                   : PC <= PC+1 when PCin is low
//   Read                    : MDR source, 1 = Mdatain, 0 = bus
//   MUL                     : ALU opcode
//   Mdatain                 : memory read data
//   Cin                     : ALU carry-in
// No outputs; state lives in reg_q and is observed hierarchically.
module cpu_project
   import cpu_pkg::*;
(
   input logic        PCout,
   input logic        ZHighout,
   input logic        Zlowout,
   input logic        MDRout,
   input logic        R2out,
   input logic        R4out,
   input logic        MARin,
   input logic        PCin,
   input logic        MDRin,
   input logic        IRin,
   input logic        Yin,
   input logic        IncPC,
   input logic        Read,
   input logic [4:0]  MUL,
   input logic        R5in,
   input logic        R2in,
   input logic        R4in,
   input logic        Clock,
   input logic [31:0] Mdatain,
   input logic        Clear,
   input logic        R1in,
   input logic        R3in,
   input logic        R6in,
   input logic        R7in,
   input logic        R8in,
   input logic        R9in,
   input logic        R10in,
   input logic        R11in,
   input logic        R12in,
   input logic        R13in,
   input logic        R14in,
   input logic        R15in,
   input logic        HIin,
   input logic        LOin,
   input logic        ZHighIn,
   input logic        ZLowIn,
   input logic        Cin
);

   word_t              bus_w;
   logic [63:0]        alu_res;
   logic [NUM_GPR:1]   gpr_in;
   logic [NUM_REGS-1:0] ld_en;
   word_t              ld_d  [NUM_REGS];
   word_t              reg_q [NUM_REGS];

   assign gpr_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in};

   always_comb begin
      if (MDRout)        bus_w = reg_q[IDX_MDR];
      else if (PCout)    bus_w = reg_q[IDX_PC];
      else if (Zlowout)  bus_w = reg_q[IDX_ZLO];
      else if (ZHighout) bus_w = reg_q[IDX_ZHI];
      else if (R2out)    bus_w = reg_q[gpr_idx(2)];
      else if (R4out)    bus_w = reg_q[gpr_idx(4)];
      else               bus_w = '0;
   end

   cpu_alu u_alu (
      .op_i  (MUL),
      .a_i   (reg_q[IDX_Y]),
      .b_i   (bus_w),
      .cin_i (Cin),
      .res_o (alu_res)
   );

   always_comb begin
      ld_en = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         ld_d[i] = bus_w;
      end
      for (int unsigned n = 1; n <= NUM_GPR; n++) begin
         ld_en[gpr_idx(n)] = gpr_in[n];
      end

      ld_en[IDX_PC]  = PCin | IncPC;
      ld_d[IDX_PC]   = PCin ? bus_w : reg_q[IDX_PC] + 32'd1;

      ld_en[IDX_MDR] = MDRin;
      ld_d[IDX_MDR]  = Read ? Mdatain : bus_w;

      ld_en[IDX_ZHI] = ZHighIn;
      ld_d[IDX_ZHI]  = alu_res[63:32];
      ld_en[IDX_ZLO] = ZLowIn;
      ld_d[IDX_ZLO]  = alu_res[31:0];

      ld_en[IDX_IR]  = IRin;
      ld_en[IDX_MAR] = MARin;
      ld_en[IDX_Y]   = Yin;
      ld_en[IDX_HI]  = HIin;
      ld_en[IDX_LO]  = LOin;
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      cpu_reg32 u_reg (
         .clk_i   (Clock),
         .rst_n_i (Clear),
         .en_i    (ld_en[g]),
         .d_i     (ld_d[g]),
         .q_o     (reg_q[g])
      );
   end

endmodule

// File: tb/tb_cpu_project.sv
module tb_cpu_project;
   import cpu_pkg::*;

   logic        Clock = 1'b0;
   logic        Clear;
   logic        PCout, ZHighout, Zlowout, MDRout, R2out, R4out;
   logic        MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
   logic        HIin, LOin, ZHighIn, ZLowIn, Cin;
   logic [4:0]  MUL;
   logic [31:0] Mdatain;
   logic [15:1] rin;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // reference state
   logic [31:0] m_r [1:15];
   logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_zh, m_zl, m_hi, m_lo;

   cpu_project dut (
      .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout), .MDRout(MDRout),
      .R2out(R2out), .R4out(R4out), .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
      .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read), .MUL(MUL),
      .R5in(rin[5]), .R2in(rin[2]), .R4in(rin[4]), .Clock(Clock),
      .Mdatain(Mdatain), .Clear(Clear), .R1in(rin[1]), .R3in(rin[3]),
      .R6in(rin[6]), .R7in(rin[7]), .R8in(rin[8]), .R9in(rin[9]),
      .R10in(rin[10]), .R11in(rin[11]), .R12in(rin[12]), .R13in(rin[13]),
      .R14in(rin[14]), .R15in(rin[15]), .HIin(HIin), .LOin(LOin),
      .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      {PCout, ZHighout, Zlowout, MDRout, R2out, R4out} = '0;
      {MARin, PCin, MDRin, IRin, Yin, IncPC, Read} = '0;
      {HIin, LOin, ZHighIn, ZLowIn, Cin} = '0;
      MUL = '0;
      rin = '0;
   endtask

   task automatic model_reset();
      for (int i = 1; i <= 15; i++) m_r[i] = '0;
      {m_pc, m_ir, m_mar, m_mdr, m_y} = '0;
      {m_zh, m_zl, m_hi, m_lo} = '0;
   endtask

   function automatic logic [31:0] model_bus();
      if (MDRout)   return m_mdr;
      if (PCout)    return m_pc;
      if (Zlowout)  return m_zl;
      if (ZHighout) return m_zh;
      if (R2out)    return m_r[2];
      if (R4out)    return m_r[4];
      return 32'h0;
   endfunction

   // Arithmetic-level ALU model over native int/longint types.
   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic c);
      int          sa = a;
      int          sb = b;
      int unsigned n  = b % 32;
      longint      p;
      logic [31:0] lo;
      case (op)
         5'd3:  return {32'h0, a + b + 32'(c)};
         5'd4:  return {32'h0, a - b - 32'(c)};
         5'd5:  return {32'h0, a & b};
         5'd6:  return {32'h0, a | b};
         5'd7:  return {32'h0, a >> n};
         5'd8:  return {32'h0, 32'(sa >>> n)};
         5'd9:  return {32'h0, a << n};
         5'd10: begin
            lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
            return {32'h0, lo};
         end
         5'd11: begin
            lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
            return {32'h0, lo};
         end
         5'd14: begin
            p = longint'(sa) * longint'(sb);
            return 64'(p);
         end
         5'd15: begin
            if (sb == 0) return {a, 32'hFFFF_FFFF};
            return {32'(sa % sb), 32'(sa / sb)};
         end
         5'd16: return {32'h0, 32'(-sb)};
         5'd17: return {32'h0, ~b};
         default: return 64'h0;
      endcase
   endfunction

   task automatic check_all(input string where);
      for (int i = 1; i <= 15; i++)
         check($sformatf("%s R%0d", where, i), dut.reg_q[i-1], m_r[i]);
      check({where, " PC"},  dut.reg_q[IDX_PC],  m_pc);
      check({where, " IR"},  dut.reg_q[IDX_IR],  m_ir);
      check({where, " MAR"}, dut.reg_q[IDX_MAR], m_mar);
      check({where, " MDR"}, dut.reg_q[IDX_MDR], m_mdr);
      check({where, " Y"},   dut.reg_q[IDX_Y],   m_y);
      check({where, " ZH"},  dut.reg_q[IDX_ZHI], m_zh);
      check({where, " ZL"},  dut.reg_q[IDX_ZLO], m_zl);
      check({where, " HI"},  dut.reg_q[IDX_HI],  m_hi);
      check({where, " LO"},  dut.reg_q[IDX_LO],  m_lo);
   endtask

   // Called just after a falling edge with controls already driven.
   task automatic cycle();
      logic [31:0] b;
      logic [63:0] r;
      #1;
      b = model_bus();
      check("bus", dut.bus_w, b);
      r = ref_alu(MUL, m_y, b, Cin);
      @(posedge Clock);
      for (int i = 1; i <= 15; i++) if (rin[i]) m_r[i] = b;
      if (PCin)       m_pc = b;
      else if (IncPC) m_pc = m_pc + 32'd1;
      if (IRin)    m_ir  = b;
      if (MARin)   m_mar = b;
      if (MDRin)   m_mdr = Read ? Mdatain : b;
      if (Yin)     m_y   = b;
      if (HIin)    m_hi  = b;
      if (LOin)    m_lo  = b;
      if (ZHighIn) m_zh  = r[63:32];
      if (ZLowIn)  m_zl  = r[31:0];
      #1;
      check_all("cyc");
      @(negedge Clock);
   endtask

   task automatic load_mdr(input logic [31:0] v);
      idle(); Read = 1'b1; MDRin = 1'b1; Mdatain = v;
      cycle();
   endtask

   task automatic mdr_to_r(input int n);
      idle(); MDRout = 1'b1; rin[n] = 1'b1;
      cycle();
   endtask

   task automatic set_y(input logic [31:0] v);
      load_mdr(v);
      idle(); MDRout = 1'b1; Yin = 1'b1;
      cycle();
   endtask

   task automatic alu_z(input logic [4:0] op, input logic c);
      idle(); MDRout = 1'b1; MUL = op; Cin = c; ZLowIn = 1'b1; ZHighIn = 1'b1;
      cycle();
   endtask

   // Assert Clear between edges with every load enabled.
   task automatic clear_mid();
      idle();
      rin = '1;
      {MARin, PCin, MDRin, IRin, Yin, IncPC, HIin, LOin, ZHighIn, ZLowIn} = '1;
      #2 Clear = 1'b0;
      #1;
      model_reset();
      check_all("clr");
      check("clr bus", dut.bus_w, 32'h0);
      @(posedge Clock);
      #1 check_all("clr hold");
      @(negedge Clock);
      Clear = 1'b1;
      idle();
   endtask

   initial begin
      logic [31:0] b;
      logic [4:0]  valid_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                      5'd10, 5'd11, 5'd14, 5'd15, 5'd16, 5'd17};
      Clear = 1'b1;
      Mdatain = '0;
      idle();
      #3 Clear = 1'b0;
      #1;
      model_reset();
      check_all("reset");
      @(negedge Clock);
      Clear = 1'b1;

      load_mdr(32'h8FFF_FFFF); mdr_to_r(2);
      check("R2 load", dut.reg_q[gpr_idx(2)], 32'h8FFF_FFFF);
      load_mdr(32'h0000_0003); mdr_to_r(4);
      check("R4 load", dut.reg_q[gpr_idx(4)], 32'h0000_0003);
      load_mdr(32'h0000_0027); mdr_to_r(5);
      check("R5 load", dut.reg_q[gpr_idx(5)], 32'h0000_0027);

      idle(); R2out = 1'b1; Yin = 1'b1; cycle();
      idle(); R4out = 1'b1; MUL = ALU_MUL; ZLowIn = 1'b1; ZHighIn = 1'b1; cycle();
      idle(); Zlowout = 1'b1; LOin = 1'b1; cycle();
      idle(); ZHighout = 1'b1; HIin = 1'b1; cycle();
      check("mul LO", dut.reg_q[IDX_LO], 32'hAFFF_FFFD);
      check("mul HI", dut.reg_q[IDX_HI], 32'hFFFF_FFFE);

      set_y(32'hFFFF_FFFF); load_mdr(32'h1);
      alu_z(ALU_ADD, 1'b0);
      check("add ZL", dut.reg_q[IDX_ZLO], 32'h0);
      check("add ZH", dut.reg_q[IDX_ZHI], 32'h0);
      alu_z(ALU_ADD, 1'b1);
      check("addc ZL", dut.reg_q[IDX_ZLO], 32'h1);

      set_y(32'hFFFF_FFF9); load_mdr(32'h2);
      alu_z(ALU_DIV, 1'b0);
      check("div ZL", dut.reg_q[IDX_ZLO], 32'hFFFF_FFFD);
      check("div ZH", dut.reg_q[IDX_ZHI], 32'hFFFF_FFFF);
      load_mdr(32'h0);
      alu_z(ALU_DIV, 1'b0);
      check("div0 ZL", dut.reg_q[IDX_ZLO], 32'hFFFF_FFFF);
      check("div0 ZH", dut.reg_q[IDX_ZHI], 32'hFFFF_FFF9);

      load_mdr(32'hFFFF_FFFF);
      idle(); MDRout = 1'b1; PCin = 1'b1; cycle();
      check("pc load", dut.reg_q[IDX_PC], 32'hFFFF_FFFF);
      idle(); IncPC = 1'b1; cycle();
      check("pc wrap", dut.reg_q[IDX_PC], 32'h0);
      load_mdr(32'h7);
      idle(); MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1; cycle();
      check("pc prio", dut.reg_q[IDX_PC], 32'h7);
      idle(); PCout = 1'b1; MARin = 1'b1; cycle();
      check("mar pc", dut.reg_q[IDX_MAR], 32'h7);

      clear_mid();

      for (int k = 0; k < 400; k++) begin
         if (k % 80 == 79) begin
            clear_mid();
         end else begin
            idle();
            MDRout   = ($urandom_range(0, 4) == 0);
            PCout    = ($urandom_range(0, 4) == 0);
            Zlowout  = ($urandom_range(0, 4) == 0);
            ZHighout = ($urandom_range(0, 4) == 0);
            R2out    = ($urandom_range(0, 3) == 0);
            R4out    = ($urandom_range(0, 3) == 0);
            rin      = 15'($urandom & $urandom);
            {MARin, PCin, MDRin, IRin, Yin, IncPC} = 6'($urandom & $urandom);
            {HIin, LOin, ZHighIn, ZLowIn} = 4'($urandom);
            Read     = 1'($urandom);
            Cin      = 1'($urandom);
            Mdatain  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            MUL      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                                  : valid_ops[$urandom_range(0, 12)];
            b = model_bus();
            if (MUL == ALU_DIV && m_y == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               MUL = ALU_ADD;
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
